// File: rtl/serial_equality_pkg.sv
// Shared types and helpers for the bit-serial equality comparator.
package serial_equality_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    RESULT  = 1'b1
  } state_t;

  // Mismatch-index width; a 1-bit word still needs a 1-bit index port.
  function automatic int idx_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_equality.sv
// Bit-serial a==b comparator: collects WIDTH LSB-first bit pairs, then holds
// an equal flag and the lowest mismatching bit index until the consumer takes it.
module serial_equality
  import serial_equality_pkg::*;
#(
  parameter  int WIDTH = 5,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a,
  input  logic             in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_equal,
  output logic [IDX_W-1:0] out_first_diff
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] first_diff;
  logic             match;
  logic             in_fire, out_fire, last_beat;

  assign in_fire   = in_valid && (state == COLLECT);
  assign out_fire  = out_ready && (state == RESULT);
  assign last_beat = (cnt == IDX_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (in_fire && last_beat) state_nxt = RESULT;
      RESULT:  if (out_fire)             state_nxt = COLLECT;
      default:                           state_nxt = COLLECT;
    endcase
  end

  // Handshake flags come from state alone; result outputs gate registered data.
  always_comb begin
    in_ready       = (state == COLLECT);
    out_valid      = (state == RESULT);
    out_equal      = (state == RESULT) && match;
    out_first_diff = (state == RESULT) ? first_diff : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      match      <= 1'b1;
      first_diff <= '0;
    end else if (in_fire) begin
      cnt <= last_beat ? '0 : cnt + IDX_W'(1);
      // Only the first mismatch is recorded; match clearing locks first_diff.
      if ((in_a != in_b) && match) begin
        match      <= 1'b0;
        first_diff <= cnt;
      end
    end else if (out_fire) begin
      match      <= 1'b1;
      first_diff <= '0;
    end
  end

endmodule

// File: tb/tb_serial_equality.sv
// Directed bench for serial_equality: a WIDTH=5 instance and a WIDTH=1 instance.
module tb_serial_equality;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_a = 1'b0, in_b = 1'b0, out_ready = 1'b1;
  logic       in_ready, out_valid, out_equal;
  logic [2:0] out_first_diff;

  logic       w1_in_valid = 1'b0, w1_in_a = 1'b0, w1_in_b = 1'b0;
  logic       w1_in_ready, w1_out_valid, w1_out_equal;
  logic [0:0] w1_out_first_diff;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  serial_equality #(.WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_equal(out_equal), .out_first_diff(out_first_diff)
  );

  serial_equality #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst(rst),
    .in_valid(w1_in_valid), .in_ready(w1_in_ready), .in_a(w1_in_a), .in_b(w1_in_b),
    .out_valid(w1_out_valid), .out_ready(1'b1),
    .out_equal(w1_out_equal), .out_first_diff(w1_out_first_diff)
  );

  // Present one bit pair at a negedge and return at the negedge after it is accepted.
  task automatic beat(input logic a_bit, input logic b_bit);
    int t;
    t = 0;
    in_valid = 1'b1; in_a = a_bit; in_b = b_bit;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      compared++; mismatched++;
      $display("FAIL beat_timeout: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [4:0] a, input logic [4:0] b);
    for (int i = 0; i < 5; i++) beat(a[i], b[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_equal !== 1'b0 || out_first_diff !== 3'd0) begin
      mismatched++;
      $display("FAIL reset_state: rdy=%0b vld=%0b eq=%0b fd=%0d required 1 0 0 0",
               in_ready, out_valid, out_equal, out_first_diff);
    end
    compared++;
    if (w1_in_ready !== 1'b1 || w1_out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state_w1: rdy=%0b vld=%0b required 1 0", w1_in_ready, w1_out_valid);
    end
  endtask

  task automatic test_equal_basic();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) beat(1'(5'd3 >> i), 1'(5'd3 >> i));
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL early_valid: out_valid=%0b required 0 after 4 beats", out_valid);
    end
    beat(1'b0, 1'b0);
    compared++;
    if (out_valid !== 1'b1 || out_equal !== 1'b1 || out_first_diff !== 3'd0 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL equal_3_3: vld=%0b eq=%0b fd=%0d rdy=%0b required 1 1 0 0",
               out_valid, out_equal, out_first_diff, in_ready);
    end
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL release_3_3: rdy=%0b vld=%0b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_mismatch();
    logic [4:0] va [4] = '{5'd1, 5'd8, 5'd16, 5'd6};
    logic [4:0] vb [4] = '{5'd2, 5'd0, 5'd0,  5'd0};
    logic [2:0] vfd[4] = '{3'd0, 3'd3, 3'd4,  3'd1};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_word(va[k], vb[k]);
      compared++;
      if (out_valid !== 1'b1 || out_equal !== 1'b0 || out_first_diff !== vfd[k]) begin
        mismatched++;
        $display("FAIL mismatch_%0d_%0d: vld=%0b eq=%0b fd=%0d required 1 0 %0d",
                 va[k], vb[k], out_valid, out_equal, out_first_diff, vfd[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    int gaps[4] = '{1, 2, 3, 1};
    logic [4:0] a;
    a = 5'd5;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      beat(a[i], a[i]);
      if (i < 4) repeat (gaps[i]) @(negedge clk);
    end
    // Offer a conflicting bit while the result is pending; it must not be taken.
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_a = 1'b1; in_b = 1'b0;
      compared++;
      if (out_valid !== 1'b1 || out_equal !== 1'b1 || out_first_diff !== 3'd0 || in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_hold_%0d: vld=%0b eq=%0b fd=%0d rdy=%0b required 1 1 0 0",
                 c, out_valid, out_equal, out_first_diff, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_release: rdy=%0b vld=%0b required 1 0", in_ready, out_valid);
    end
    send_word(5'd2, 5'd0);
    compared++;
    if (out_valid !== 1'b1 || out_equal !== 1'b0 || out_first_diff !== 3'd1) begin
      mismatched++;
      $display("FAIL after_stall_2_0: vld=%0b eq=%0b fd=%0d required 1 0 1",
               out_valid, out_equal, out_first_diff);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midword();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_word(5'd31, 5'd31);
    compared++;
    if (out_valid !== 1'b1 || out_equal !== 1'b1 || out_first_diff !== 3'd0) begin
      mismatched++;
      $display("FAIL reset_midword: vld=%0b eq=%0b fd=%0d required 1 1 0",
               out_valid, out_equal, out_first_diff);
    end
    @(negedge clk);
    // Pending result discarded by reset, even with a simultaneous handshake.
    out_ready = 1'b0;
    send_word(5'd1, 5'd0);
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_equal !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_result: vld=%0b rdy=%0b eq=%0b required 0 1 0",
               out_valid, in_ready, out_equal);
    end
    send_word(5'd4, 5'd0);
    compared++;
    if (out_valid !== 1'b1 || out_equal !== 1'b0 || out_first_diff !== 3'd2) begin
      mismatched++;
      $display("FAIL after_reset_4_0: vld=%0b eq=%0b fd=%0d required 1 0 2",
               out_valid, out_equal, out_first_diff);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic       exp_eq[16];
    logic [2:0] exp_fd[16];
    int         n;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        exp_eq[a*4+b] = (a == b);
        exp_fd[a*4+b] = ((a ^ b) & 1) != 0 ? 3'd0 : (((a ^ b) & 2) != 0 ? 3'd1 : 3'd0);
      end
    n = 0;
    fork
      begin
        for (int a = 0; a < 4; a++)
          for (int b = 0; b < 4; b++) send_word(5'(a), 5'(b));
      end
      begin
        int cyc;
        logic r;
        cyc = 0;
        while (n < 16 && cyc < 3000) begin
          r = 1'($urandom_range(0, 1));
          out_ready = r;
          if (out_valid && r) begin
            compared++;
            if (out_equal !== exp_eq[n] || out_first_diff !== exp_fd[n]) begin
              mismatched++;
              $display("FAIL b2b_%0d: eq=%0b fd=%0d required %0b %0d",
                       n, out_equal, out_first_diff, exp_eq[n], exp_fd[n]);
            end
            n++;
          end
          @(negedge clk);
          cyc++;
        end
      end
    join
    out_ready = 1'b1;
    @(negedge clk);
    compared++;
    if (n != 16 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_count: results=%0d vld=%0b required 16 0", n, out_valid);
    end
  endtask

  task automatic test_width1();
    logic va[3] = '{1'b0, 1'b1, 1'b1};
    logic vb[3] = '{1'b0, 1'b0, 1'b1};
    logic ve[3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      int t;
      t = 0;
      w1_in_valid = 1'b1; w1_in_a = va[k]; w1_in_b = vb[k];
      while (!w1_in_ready && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
      w1_in_valid = 1'b0;
      compared++;
      if (w1_out_valid !== 1'b1 || w1_out_equal !== ve[k] || w1_out_first_diff !== 1'b0) begin
        mismatched++;
        $display("FAIL w1_beat_%0d: vld=%0b eq=%0b fd=%0d required 1 %0b 0",
                 k, w1_out_valid, w1_out_equal, w1_out_first_diff, ve[k]);
      end
      @(negedge clk);
      compared++;
      if (w1_in_ready !== 1'b1 || w1_out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL w1_release_%0d: rdy=%0b vld=%0b required 1 0", k, w1_in_ready, w1_out_valid);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_equal_basic();
    test_mismatch();
    test_stall();
    test_reset_midword();
    test_back_to_back();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
